// File: rtl/csr_issue_sched.sv
// csr_issue_sched
//   Queues CSR instructions from issue and releases them one at a time to the
//   bypass FIFO. A new CSR issues only after write-back retires the previous
//   one. Also exports empty / IsFirst / gray read pointer status for the CSR
//   FIFO permit logic.
//
// Ports
//   clk, rstn                     clock, async active-low reset
//   i_DriveFromIssue_1            issue offers an instruction
//   o_FreeToIssue_1               queue not full (registered)
//   i_InstructionToCsrIssue_113   instruction from issue
//   o_DriveCsrIssueToBypassFifo   issued instruction valid
//   i_FreeBypassFifoToCsrIssue    bypass FIFO accepts
//   o_InstructionOut_113          registered issued instruction
//   i_DriveFromWriteBack_1        outstanding CSR retired
//   o_FreeToWriteBack_1           retire report accepted (WAIT_WB)
//   i_Flush_1                     drop queued, un-issued entries
//   o_empty_1, o_CSRCount_5       queue empty / occupancy
//   o_IsFirst_1                   no CSR outstanding
//   o_RdPtrGray_5                 gray-coded read pointer
//   o_ProtoErr_1                  sticky: retire report outside WAIT_WB
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | nothing outstanding; pops the queue head when not empty
// S_ISSUE   | instruction presented to bypass FIFO, held until accepted
// S_WAIT_WB | instruction in flight, waiting for write-back retire
module csr_issue_sched #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int INSTR_W = 113
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_DriveFromIssue_1,
   output logic               o_FreeToIssue_1,
   input  logic [INSTR_W-1:0] i_InstructionToCsrIssue_113,
   output logic               o_DriveCsrIssueToBypassFifo,
   input  logic               i_FreeBypassFifoToCsrIssue,
   output logic [INSTR_W-1:0] o_InstructionOut_113,
   input  logic               i_DriveFromWriteBack_1,
   output logic               o_FreeToWriteBack_1,
   input  logic               i_Flush_1,
   output logic               o_empty_1,
   output logic               o_IsFirst_1,
   output logic [AW:0]        o_CSRCount_5,
   output logic [AW:0]        o_RdPtrGray_5,
   output logic               o_ProtoErr_1
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT_WB = 2'd2
   } state_t;

   state_t             state;
   logic [AW:0]        wr;
   logic [AW:0]        rd;
   logic [AW:0]        wr_nxt;
   logic [AW:0]        rd_nxt;
   logic [AW:0]        count_nxt;
   logic               push;
   logic               pop;
   logic               full_nxt;
   logic [INSTR_W-1:0] mem [DEPTH];

   // Free and empty are registered, so a pop in the same cycle never frees a
   // slot for a push until the following cycle.
   always_comb begin
      push      = i_DriveFromIssue_1 & o_FreeToIssue_1 & ~i_Flush_1;
      pop       = (state == S_IDLE) & ~o_empty_1 & ~i_Flush_1;
      wr_nxt    = wr + {{AW{1'b0}}, push};
      if (i_Flush_1)
         rd_nxt = wr_nxt;
      else
         rd_nxt = rd + {{AW{1'b0}}, pop};
      count_nxt = wr_nxt - rd_nxt;
      full_nxt  = (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr[AW-1:0]] <= i_InstructionToCsrIssue_113;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state                       <= S_IDLE;
         wr                          <= '0;
         rd                          <= '0;
         o_FreeToIssue_1             <= 1'b1;
         o_DriveCsrIssueToBypassFifo <= 1'b0;
         o_InstructionOut_113        <= '0;
         o_FreeToWriteBack_1         <= 1'b0;
         o_empty_1                   <= 1'b1;
         o_IsFirst_1                 <= 1'b1;
         o_CSRCount_5                <= '0;
         o_RdPtrGray_5               <= '0;
         o_ProtoErr_1                <= 1'b0;
      end else begin
         wr              <= wr_nxt;
         rd              <= rd_nxt;
         o_empty_1       <= (wr_nxt == rd_nxt);
         o_CSRCount_5    <= count_nxt;
         o_RdPtrGray_5   <= rd_nxt ^ (rd_nxt >> 1);
         o_FreeToIssue_1 <= ~full_nxt;

         if (i_DriveFromWriteBack_1 && (state != S_WAIT_WB))
            o_ProtoErr_1 <= 1'b1;

         case (state)
            S_IDLE: begin
               if (pop) begin
                  o_InstructionOut_113        <= mem[rd[AW-1:0]];
                  o_DriveCsrIssueToBypassFifo <= 1'b1;
                  o_IsFirst_1                 <= 1'b0;
                  state                       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // An accepted handshake is already in flight, so it beats a flush.
               if (i_FreeBypassFifoToCsrIssue) begin
                  o_DriveCsrIssueToBypassFifo <= 1'b0;
                  o_FreeToWriteBack_1         <= 1'b1;
                  state                       <= S_WAIT_WB;
               end else if (i_Flush_1) begin
                  o_DriveCsrIssueToBypassFifo <= 1'b0;
                  o_IsFirst_1                 <= 1'b1;
                  state                       <= S_IDLE;
               end
            end
            S_WAIT_WB: begin
               if (i_DriveFromWriteBack_1) begin
                  o_FreeToWriteBack_1 <= 1'b0;
                  o_IsFirst_1         <= 1'b1;
                  state               <= S_IDLE;
               end
            end
            default: begin
               o_DriveCsrIssueToBypassFifo <= 1'b0;
               o_FreeToWriteBack_1         <= 1'b0;
               o_IsFirst_1                 <= 1'b1;
               state                       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_issue_sched.sv
// Directed bench for csr_issue_sched: reset, single CSR latency,
// serialization/backpressure, flush, protocol error, full and pointer wrap.
module tb_csr_issue_sched;
   localparam int IW = 113;

   logic          clk = 1'b0;
   logic          rstn;
   logic          drive_issue;
   logic          free_issue;
   logic [IW-1:0] instr_in;
   logic          valid;
   logic          bypass_free;
   logic [IW-1:0] instr_out;
   logic          wb;
   logic          free_wb;
   logic          flush;
   logic          empty;
   logic          is_first;
   logic [4:0]    count;
   logic [4:0]    rd_gray;
   logic          proto_err;

   int n_chk = 0;
   int n_err = 0;

   logic [IW-1:0] q[$];
   int            exp_rd;
   logic [4:0]    prev_g;
   logic [4:0]    g_exp;
   logic          wrap_seen;

   always #5 clk = ~clk;

   csr_issue_sched dut (
      .clk                         (clk),
      .rstn                        (rstn),
      .i_DriveFromIssue_1          (drive_issue),
      .o_FreeToIssue_1             (free_issue),
      .i_InstructionToCsrIssue_113 (instr_in),
      .o_DriveCsrIssueToBypassFifo (valid),
      .i_FreeBypassFifoToCsrIssue  (bypass_free),
      .o_InstructionOut_113        (instr_out),
      .i_DriveFromWriteBack_1      (wb),
      .o_FreeToWriteBack_1         (free_wb),
      .i_Flush_1                   (flush),
      .o_empty_1                   (empty),
      .o_IsFirst_1                 (is_first),
      .o_CSRCount_5                (count),
      .o_RdPtrGray_5               (rd_gray),
      .o_ProtoErr_1                (proto_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !valid; i++)
         step();
      chk("valid_wait", 128'(valid), 128'(1));
   endtask

   // Check the head CSR and its read pointer, hand it off, then retire it.
   task automatic drain_one();
      wait_valid(6);
      exp_rd = (exp_rd + 1) % 32;
      g_exp  = 5'(exp_rd) ^ (5'(exp_rd) >> 1);
      chk("order", 128'(instr_out), 128'(q.pop_front()));
      chk("rd_gray", 128'(rd_gray), 128'(g_exp));
      chk("gray_step", 128'($countones(prev_g ^ rd_gray)), 128'(1));
      if (prev_g == 5'b10000 && rd_gray == 5'b00000)
         wrap_seen = 1'b1;
      prev_g = rd_gray;
      step();
      wb = 1'b1;
      step();
      wb = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rstn        = 1'b0;
      drive_issue = 1'b0;
      instr_in    = '0;
      bypass_free = 1'b0;
      wb          = 1'b0;
      flush       = 1'b0;
      wrap_seen   = 1'b0;
      exp_rd      = 0;
      prev_g      = '0;
      step();
      step();
      rstn = 1'b1;
      step();

      // reset values
      chk("rst_valid", 128'(valid), 128'(0));
      chk("rst_instr", 128'(instr_out), 128'(0));
      chk("rst_free", 128'(free_issue), 128'(1));
      chk("rst_free_wb", 128'(free_wb), 128'(0));
      chk("rst_empty", 128'(empty), 128'(1));
      chk("rst_first", 128'(is_first), 128'(1));
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_gray", 128'(rd_gray), 128'(0));
      chk("rst_proto", 128'(proto_err), 128'(0));

      // single CSR, bypass always free
      bypass_free = 1'b1;
      drive_issue = 1'b1;
      instr_in    = IW'(32'h1ABC);
      step();
      drive_issue = 1'b0;
      chk("s_c1_count", 128'(count), 128'(1));
      chk("s_c1_valid", 128'(valid), 128'(0));
      chk("s_c1_empty", 128'(empty), 128'(0));
      step();
      chk("s_c2_valid", 128'(valid), 128'(1));
      chk("s_c2_instr", 128'(instr_out), 128'(32'h1ABC));
      chk("s_c2_count", 128'(count), 128'(0));
      chk("s_c2_first", 128'(is_first), 128'(0));
      step();
      chk("s_c3_valid", 128'(valid), 128'(0));
      chk("s_c3_free_wb", 128'(free_wb), 128'(1));
      step();
      step();
      wb = 1'b1;
      step();
      wb = 1'b0;
      chk("s_c6_first", 128'(is_first), 128'(1));
      chk("s_c6_free_wb", 128'(free_wb), 128'(0));
      chk("s_c6_proto", 128'(proto_err), 128'(0));

      // serialization and backpressure
      bypass_free = 1'b0;
      drive_issue = 1'b1;
      instr_in    = IW'(32'hA);
      step();
      instr_in    = IW'(32'hB);
      step();
      drive_issue = 1'b0;
      chk("bp_count", 128'(count), 128'(1));
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid_hold", 128'(valid), 128'(1));
         chk("bp_instr_hold", 128'(instr_out), 128'(32'hA));
         step();
      end
      chk("bp_valid_after", 128'(valid), 128'(1));
      bypass_free = 1'b1;
      step();
      chk("bp_wait_valid", 128'(valid), 128'(0));
      chk("bp_wait_free_wb", 128'(free_wb), 128'(1));
      step();
      chk("bp_b_not_issued", 128'(valid), 128'(0));
      chk("bp_b_queued", 128'(count), 128'(1));
      wb = 1'b1;
      step();
      wb = 1'b0;
      chk("bp_wb1_valid", 128'(valid), 128'(0));
      chk("bp_wb1_first", 128'(is_first), 128'(1));
      step();
      chk("bp_wb2_valid", 128'(valid), 128'(1));
      chk("bp_wb2_instr", 128'(instr_out), 128'(32'hB));
      step();
      wb = 1'b1;
      step();
      wb = 1'b0;

      // flush while in ISSUE with 5 queued
      bypass_free = 1'b0;
      drive_issue = 1'b1;
      for (int i = 0; i < 6; i++) begin
         instr_in = IW'(32'h200 + i);
         step();
      end
      drive_issue = 1'b0;
      chk("fi_count", 128'(count), 128'(5));
      chk("fi_valid", 128'(valid), 128'(1));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fi_empty", 128'(empty), 128'(1));
      chk("fi_count0", 128'(count), 128'(0));
      chk("fi_valid0", 128'(valid), 128'(0));
      chk("fi_first", 128'(is_first), 128'(1));
      step();
      chk("fi_no_issue", 128'(valid), 128'(0));

      // flush while in WAIT_WB
      drive_issue = 1'b1;
      for (int i = 0; i < 3; i++) begin
         instr_in = IW'(32'h300 + i);
         step();
      end
      drive_issue = 1'b0;
      chk("fw_count", 128'(count), 128'(2));
      bypass_free = 1'b1;
      step();
      bypass_free = 1'b0;
      chk("fw_free_wb", 128'(free_wb), 128'(1));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fw_kept_wait", 128'(free_wb), 128'(1));
      chk("fw_first", 128'(is_first), 128'(0));
      chk("fw_empty", 128'(empty), 128'(1));
      chk("fw_count0", 128'(count), 128'(0));
      wb = 1'b1;
      step();
      wb = 1'b0;
      chk("fw_wb_first", 128'(is_first), 128'(1));
      chk("fw_wb_free_wb", 128'(free_wb), 128'(0));
      chk("fw_proto", 128'(proto_err), 128'(0));
      step();
      chk("fw_no_issue", 128'(valid), 128'(0));

      // protocol error: retire report while IDLE
      wb = 1'b1;
      step();
      wb = 1'b0;
      chk("pe_set", 128'(proto_err), 128'(1));
      chk("pe_first", 128'(is_first), 128'(1));
      chk("pe_free_wb", 128'(free_wb), 128'(0));
      drive_issue = 1'b1;
      instr_in    = IW'(32'h55);
      step();
      drive_issue = 1'b0;
      step();
      chk("pe_flow_valid", 128'(valid), 128'(1));
      chk("pe_flow_instr", 128'(instr_out), 128'(32'h55));
      bypass_free = 1'b1;
      step();
      bypass_free = 1'b0;
      wb = 1'b1;
      step();
      wb = 1'b0;
      chk("pe_flow_first", 128'(is_first), 128'(1));
      chk("pe_sticky", 128'(proto_err), 128'(1));

      // asynchronous reset mid-ISSUE with 3 queued
      drive_issue = 1'b1;
      for (int i = 0; i < 4; i++) begin
         instr_in = IW'(32'h400 + i);
         step();
      end
      drive_issue = 1'b0;
      chk("ar_pre_count", 128'(count), 128'(3));
      chk("ar_pre_valid", 128'(valid), 128'(1));
      rstn = 1'b0;
      #1;
      chk("ar_valid", 128'(valid), 128'(0));
      chk("ar_instr", 128'(instr_out), 128'(0));
      chk("ar_count", 128'(count), 128'(0));
      chk("ar_empty", 128'(empty), 128'(1));
      chk("ar_first", 128'(is_first), 128'(1));
      chk("ar_free", 128'(free_issue), 128'(1));
      chk("ar_gray", 128'(rd_gray), 128'(0));
      chk("ar_proto", 128'(proto_err), 128'(0));
      step();
      rstn = 1'b1;
      step();
      chk("ar_rel_count", 128'(count), 128'(0));
      chk("ar_rel_first", 128'(is_first), 128'(1));
      chk("ar_rel_valid", 128'(valid), 128'(0));

      // full: 16 pushes with the head held in ISSUE
      bypass_free = 1'b0;
      drive_issue = 1'b1;
      for (int i = 0; i < 16; i++) begin
         instr_in = IW'(32'h1000 + i);
         q.push_back(instr_in);
         step();
      end
      drive_issue = 1'b0;
      chk("full_count15", 128'(count), 128'(15));
      chk("full_free15", 128'(free_issue), 128'(1));
      drive_issue = 1'b1;
      instr_in    = IW'(32'h1010);
      q.push_back(instr_in);
      step();
      chk("full_count16", 128'(count), 128'(16));
      chk("full_free16", 128'(free_issue), 128'(0));
      instr_in = IW'(32'hDEAD);
      step();
      drive_issue = 1'b0;
      chk("full_ignored", 128'(count), 128'(16));
      chk("full_still", 128'(free_issue), 128'(0));

      // drain the full queue, then 40 CSRs end-to-end across the pointer wrap
      bypass_free = 1'b1;
      while (q.size() > 0)
         drain_one();
      chk("drain_empty", 128'(empty), 128'(1));
      for (int i = 0; i < 40; i++) begin
         drive_issue = 1'b1;
         instr_in    = {IW'(32'hC500 + i)} | (IW'(i) << 100);
         q.push_back(instr_in);
         step();
         drive_issue = 1'b0;
         drain_one();
      end
      chk("wrap_seen", 128'(wrap_seen), 128'(1));
      chk("end_count", 128'(count), 128'(0));
      chk("end_first", 128'(is_first), 128'(1));
      chk("end_proto", 128'(proto_err), 128'(0));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
